// File: rtl/popcnt_pkg.sv
// Shared types and helpers for the serial population counter.
package popcnt_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic MODE_ONES  = 1'b0;
  localparam logic MODE_ZEROS = 1'b1;

  // Bits needed to hold any value 0..n inclusive.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/popcnt_slice.sv
// Combinational popcount of one SLICE_W-bit slice.
module popcnt_slice
  import popcnt_pkg::*;
#(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0]            bits,
  output logic [cnt_width(SLICE_W)-1:0] count
);

  localparam int CW = cnt_width(SLICE_W);

  always_comb begin
    count = '0;
    for (int i = 0; i < SLICE_W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/popcnt_serial.sv
// Multi-cycle population counter: BITS_PER_CYC bits per clock, ones or zeros.
// Define POPCNT_PARITY_EN to add the out_parity output.
module popcnt_serial
  import popcnt_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int BITS_PER_CYC = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [cnt_width(DATA_W)-1:0]  out_count
`ifdef POPCNT_PARITY_EN
  ,
  output logic                          out_parity
`endif
);

  localparam int NUM_STEPS = (DATA_W + BITS_PER_CYC - 1) / BITS_PER_CYC;
  localparam int PAD_W     = NUM_STEPS * BITS_PER_CYC;
  localparam int CNT_W     = cnt_width(DATA_W);
  localparam int SLC_W     = cnt_width(BITS_PER_CYC);
  localparam int STEP_W    = cnt_width(NUM_STEPS);

  // Handshake: a transfer happens on a rising edge where valid && ready.
  // ready and valid here are pure state decodes, never functions of inputs.
  state_t              state, state_nxt;
  logic [PAD_W-1:0]    shreg;
  logic [PAD_W-1:0]    cap;
  logic [CNT_W-1:0]    acc;
  logic [STEP_W-1:0]   step_idx;
  logic [SLC_W-1:0]    slice_cnt;
  logic                accept;
  logic                last_step;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_count = acc;
  assign accept    = in_valid && in_ready;
  assign last_step = (step_idx == STEP_W'(NUM_STEPS - 1));

`ifdef POPCNT_PARITY_EN
  assign out_parity = acc[0];
`endif

  // Padding bits above DATA_W stay zero so they never count in either mode.
  always_comb begin
    cap = '0;
    cap[DATA_W-1:0] = (in_mode == MODE_ZEROS) ? ~in_data : in_data;
  end

  popcnt_slice #(
    .SLICE_W(BITS_PER_CYC)
  ) u_slice (
    .bits  (shreg[BITS_PER_CYC-1:0]),
    .count (slice_cnt)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = COUNT;
      COUNT:   if (last_step) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg    <= '0;
      acc      <= '0;
      step_idx <= '0;
    end else if (accept) begin
      shreg    <= cap;
      acc      <= '0;
      step_idx <= '0;
    end else if (state == COUNT) begin
      acc      <= acc + CNT_W'(slice_cnt);
      shreg    <= shreg >> BITS_PER_CYC;
      step_idx <= step_idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_popcnt_serial.sv
// Self-checking bench for popcnt_serial: 16/4 and 10/4 configurations.
module tb_popcnt_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready;
  logic [15:0] a_in_data;
  logic [4:0]  a_out_count;
  logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready;
  logic [9:0]  b_in_data;
  logic [3:0]  b_out_count;
`ifdef POPCNT_PARITY_EN
  logic        a_out_parity, b_out_parity;
`endif

  popcnt_serial #(.DATA_W(16), .BITS_PER_CYC(4)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count)
`ifdef POPCNT_PARITY_EN
    , .out_parity(a_out_parity)
`endif
  );

  popcnt_serial #(.DATA_W(10), .BITS_PER_CYC(4)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count)
`ifdef POPCNT_PARITY_EN
    , .out_parity(b_out_parity)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: count set bits of the word, or the complement within w bits.
  function automatic int model(input int w, input logic [31:0] d, input logic mode);
    int ones;
    ones = $countones(d & ((32'd1 << w) - 32'd1));
    return mode ? (w - ones) : ones;
  endfunction

  task automatic send_a(input logic [15:0] d, input logic mode, input int hold,
                        input int exp, input string tag);
    int lat;
    @(negedge clk);
    check({tag, " in_ready"}, a_in_ready, 1);
    a_in_valid = 1'b1; a_in_data = d; a_in_mode = mode; a_out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    // Inputs change after capture; the result must not depend on them.
    a_in_valid = 1'b0; a_in_data = ~d; a_in_mode = ~mode;
    while (!a_out_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check({tag, " latency"}, lat, 5);
    for (int k = 0; k < hold; k++) begin
      check({tag, " hold valid"}, a_out_valid, 1);
      check({tag, " hold count"}, a_out_count, exp);
      @(negedge clk);
    end
    check({tag, " count"}, a_out_count, exp);
`ifdef POPCNT_PARITY_EN
    check({tag, " parity"}, a_out_parity, exp % 2);
`endif
    a_out_ready = 1'b1;
    @(negedge clk);
    check({tag, " valid drop"}, a_out_valid, 0);
    check({tag, " count kept"}, a_out_count, exp);
    a_out_ready = 1'b0;
  endtask

  task automatic send_b(input logic [9:0] d, input logic mode, input int exp, input string tag);
    int lat;
    @(negedge clk);
    b_in_valid = 1'b1; b_in_data = d; b_in_mode = mode; b_out_ready = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    b_in_valid = 1'b0;
    while (!b_out_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check({tag, " latency"}, lat, 4);
    check({tag, " count"}, b_out_count, exp);
    b_out_ready = 1'b1;
    @(negedge clk);
    check({tag, " valid drop"}, b_out_valid, 0);
    b_out_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] data;
    logic        mode;
    int          hold;
    int          exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] rd;
    logic        rm;
    int          lat;
    logic        seen;

    vecs[0] = '{16'hFFFF, 1'b0, 3, 16};
    vecs[1] = '{16'hA5F0, 1'b0, 0, 8};
    vecs[2] = '{16'hA5F0, 1'b1, 1, 8};
    vecs[3] = '{16'h0000, 1'b1, 0, 16};
    vecs[4] = '{16'h0001, 1'b0, 2, 1};
    vecs[5] = '{16'h8000, 1'b1, 0, 15};

    reset = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 1'b0; b_out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset in_ready", a_in_ready, 1);
    check("reset out_valid", a_out_valid, 0);
    check("reset out_count", a_out_count, 0);
    reset = 1'b1;
    a_out_ready = 1'b1;
    @(negedge clk);
    check("idle out_ready ignored", a_out_valid, 0);
    check("post-reset in_ready", a_in_ready, 1);
    a_out_ready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      send_a(vecs[i].data, vecs[i].mode, vecs[i].hold, vecs[i].exp, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      rd = 16'($urandom);
      rm = 1'($urandom_range(0, 1));
      send_a(rd, rm, $urandom_range(0, 2), model(16, 32'(rd), rm), $sformatf("rnd%0d", i));
    end

    send_b(10'h3FF, 1'b1, 0, "w10 zeros");
    send_b(10'h3FF, 1'b0, 10, "w10 ones");
    send_b(10'h000, 1'b1, 10, "w10 pad");
    for (int i = 0; i < 8; i++) begin
      rd = 16'($urandom);
      rm = 1'($urandom_range(0, 1));
      send_b(rd[9:0], rm, model(10, 32'(rd[9:0]), rm), $sformatf("w10 rnd%0d", i));
    end

    // Reset during the second COUNT cycle discards the word.
    @(negedge clk);
    a_in_valid = 1'b1; a_in_data = 16'hF0F0; a_in_mode = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midreset in_ready", a_in_ready, 1);
    check("midreset out_valid", a_out_valid, 0);
    check("midreset out_count", a_out_count, 0);
    reset = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (a_out_valid) seen = 1'b1;
    end
    check("midreset no result", seen, 0);
    send_a(16'h00FF, 1'b0, 0, 8, "after reset");

    // in_valid held high with churning data while busy.
    @(negedge clk);
    a_out_ready = 1'b1;
    a_in_valid = 1'b1; a_in_data = 16'h1234; a_in_mode = 1'b0;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    while (!a_out_valid && lat < 40) begin
      a_in_data = 16'($urandom);
      a_in_mode = 1'($urandom_range(0, 1));
      @(posedge clk); lat++; @(negedge clk);
    end
    check("busy latency", lat, 5);
    check("busy first count", a_out_count, model(16, 32'h1234, 1'b0));
    a_in_data = 16'hF00F; a_in_mode = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("busy back to idle", a_in_ready, 1);
    check("busy idle valid", a_out_valid, 0);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    a_in_valid = 1'b0;
    while (!a_out_valid && lat < 40) begin
      @(posedge clk); lat++; @(negedge clk);
    end
    check("busy second latency", lat, 5);
    check("busy second count", a_out_count, model(16, 32'hF00F, 1'b1));
    @(negedge clk);
    a_out_ready = 1'b0;
    check("busy final idle", a_in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/popcnt_serial.md
Name: popcnt_serial

Overview:
- Parametrised multi-cycle population counter: captures a DATA_W-bit word, counts ones or zeros BITS_PER_CYC bits per clock, and presents the result through a valid/ready handshake.
- Next generation of the team's serial ones-counter. Adds configurable width and throughput, a count-zeros mode, a full-range result width and proper input/output handshakes.
- Sits between a word producer and any consumer needing bit-density statistics.

Parameters:
- DATA_W, 16: input word width; must be ≥1.
- BITS_PER_CYC, 4: bits examined per counting cycle; 1 ≤ BITS_PER_CYC ≤ DATA_W.
- Derived NUM_STEPS = ceil(DATA_W/BITS_PER_CYC) (not overridable).
- Derived CNT_W = $clog2(DATA_W+1) (not overridable).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset; state is cleared on a clk edge where reset==0.
- in_valid  in  1  in_data/in_mode valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_W  word to count.
- in_mode  in  1  0 = count ones, 1 = count zeros; sampled with in_data.
- out_valid  out  1  out_count valid.
- out_ready  in  1  consumer accepts result.
- out_count  out  CNT_W  result.

Behaviour:
- Reset (reset==0 at edge):
  - state=IDLE, in_ready=1, out_valid=0, out_count=0, step index=0.
  - Captured word is don't-care.
- States:
  - IDLE, COUNT, DONE.
  - in_ready = (state==IDLE); out_valid = (state==DONE); both are registered/state-decoded, with no combinational input→output path.
- IDLE:
  - On in_valid && in_ready: capture shift register = in_mode ? ~in_data : in_data.
  - Bit positions ≥DATA_W in the padded NUM_STEPS*BITS_PER_CYC register are forced to 0, so padding never counts in either mode.
  - Clear accumulator and step index; go to COUNT.
  - in_valid without acceptance has no effect.
- COUNT:
  - Each cycle: accumulator += popcount of the lowest BITS_PER_CYC bits of the shift register; shift right by BITS_PER_CYC; step index +1.
  - After NUM_STEPS counting cycles, go to DONE; the accumulator holds the final value.
  - in_valid is ignored (in_ready=0).
- DONE:
  - out_count holds the result, stable while out_valid=1 && out_ready=0.
  - On out_ready: go to IDLE, out_valid drops next cycle.
  - out_count keeps its last value until the next acceptance clears it.
- Latency: out_valid rises NUM_STEPS+1 edges after the accept edge.
  - Default: 5 cycles.
  - Throughput: one word per NUM_STEPS+2 cycles with out_ready held high.
- Arithmetic:
  - Accumulator is CNT_W bits and cannot overflow; max value is DATA_W (16 → 5'd16).
  - Slice popcount is $clog2(BITS_PER_CYC+1) bits, zero-extended before the add.
- Boundaries:
  - DATA_W==BITS_PER_CYC: NUM_STEPS=1.
  - Partial final slice is zero-padded.
  - out_ready asserted while not DONE is ignored.
  - Reset mid-COUNT or mid-DONE: in-flight word is discarded, next edge returns to IDLE, and no out_valid is produced for it.
  - in_mode change during COUNT has no effect.

Optional Feature:
- POPCNT_PARITY_EN defined:
  - Adds output out_parity (1 bit) = XOR of counted bits = out_count[0].
  - Registered with out_count; valid under out_valid; reset 0.
- Undefined: port absent, no extra logic.

Decomposition:
- popcnt_pkg holds:
  - state enum (IDLE, COUNT, DONE);
  - mode constants MODE_ONES=1'b0, MODE_ZEROS=1'b1;
  - function cnt_width(n) returning $clog2(n+1).
- Sub-module popcnt_slice (combinational, parameter SLICE_W): SLICE_W-bit vector → count. Instantiated once with SLICE_W=BITS_PER_CYC.

Test Plan (DATA_W=16, BITS_PER_CYC=4 unless noted):
- Reset hold 2 cycles then release → in_ready=1, out_valid=0, out_count=0.
- Accept 16'hFFFF, mode 0 → out_valid exactly 5 edges after accept, out_count=5'd16; with out_ready=0 for 3 cycles, value holds, then clears on handshake.
- Accept 16'hA5F0, mode 0 → 8; same word mode 1 → 8; 16'h0000 mode 1 → 16; 16'h0001 mode 0 → 1.
- DATA_W=10, BITS_PER_CYC=4, accept 10'h3FF mode 1 → 0, and mode 0 → 10; padding never counted; latency 4.
- Assert reset (0) at 2nd COUNT cycle → no out_valid; in_ready=1 next edge; a subsequent 16'h00FF counts → 8.
- in_valid held high during COUNT/DONE with a changing in_data → ignored; the first word's result is correct and the second word is accepted only after return to IDLE.
